led_fader: RTL

//  Downstream stage of the 1 Hz rotating LED shifter: consumes its NUM_CH-bit on/off pattern and drives the board LEDs.
//  - Each LED ramps its brightness linearly toward its target, full on or off, one step per fade tick.
//  - Brightness is rendered by a shared free-running PWM counter, so pattern rotations cross-fade instead of snapping.

---
 rtl/led_fader.sv | 78 +++++++
 1 files changed

// File: rtl/led_fader.sv
// Fades each LED channel linearly toward its on/off target and renders brightness with a shared PWM counter.
// Latency: pattern_in -> led_out is 3 cycles when fade_en=0; no backpressure (free-running outputs).
module led_fader #(
    parameter int NUM_CH   = 4,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 390625
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pattern_in,
    input  logic              fade_en,
    output logic [NUM_CH-1:0] led_out,
    output logic              busy
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
    localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [NUM_CH-1:0]   pattern_q;
    logic [PWM_BITS-1:0] level [NUM_CH];
    logic [PRE_W-1:0]    prescaler;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= '0;
            prescaler <= '0;
            step_tick <= 1'b0;
            pwm_cnt   <= '0;
            led_out   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                level[i] <= '0;
            end
        end else begin
            pattern_q <= pattern_in;

            if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                step_tick <= 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
                step_tick <= 1'b0;
            end

            // Counter stops one short of MAX so level MAX stays high for the whole period.
            if (pwm_cnt == MAX - 1'b1) begin
                pwm_cnt <= '0;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (!fade_en) begin
                    level[i] <= pattern_q[i] ? MAX : '0;
                end else if (step_tick) begin
                    if (pattern_q[i] && level[i] != MAX) begin
                        level[i] <= level[i] + 1'b1;
                    end else if (!pattern_q[i] && level[i] != '0) begin
                        level[i] <= level[i] - 1'b1;
                    end
                end
                led_out[i] <= (level[i] > pwm_cnt);
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (level[i] != (pattern_q[i] ? MAX : '0)) begin
                busy = 1'b1;
            end
        end
    end

endmodule
